// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file writeback
//               arbiter: register/data widths, the requester enum used as the
//               round-robin pointer, and the writeback request struct.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 1 << REG_ID_W;

  // Which requester currently holds priority on a conflict.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  // One writeback request as seen at the arbiter input.
  typedef struct packed {
    logic                valid;
    logic [REG_ID_W-1:0] reg_id;
    logic [DATA_W-1:0]   data;
  } wb_req_t;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_picker
// Description : Two-way round-robin grant with its priority pointer.
//               A grant never depends on the requester's own valid: a side is
//               blocked only when the other side is valid and holds priority.
//               The pointer flips only on a true conflict (both valid).
// Ports       : clk, rst_n         - clock, async active-low reset
//               a_valid, b_valid   - requests from A (ALU) and B (load)
//               a_grant, b_grant   - grants (ready) back to the requesters
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_picker
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  req_e r_prio;
  req_e w_prio_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= REQ_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // Next-state: the side that just won a conflict hands priority over.
  always_comb begin
    w_prio_nxt = r_prio;
    if (a_valid && b_valid) begin
      w_prio_nxt = other_req(r_prio);
    end
  end

  // Outputs
  always_comb begin
    a_grant = !(b_valid && (r_prio == REQ_B));
    b_grant = !(a_valid && (r_prio == REQ_A));
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between the ALU
//               (A) and load (B) writeback paths. The winning request is
//               registered toward the register file (1-cycle latency), and a
//               per-register pending-write scoreboard lets decode stall on
//               sources whose producer has not yet written back.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               a_valid/a_ready/a_reg/a_data    - requester A handshake
//               b_valid/b_ready/b_reg/b_data    - requester B handshake
//               wr_en/wr_reg/wr_data            - registered register-file write
//               rsv_en/rsv_reg                  - decode destination reservation
//               src1_reg/src2_reg               - decode source lookups
//               src1_busy/src2_busy             - source has a pending write
//               busy                            - full scoreboard vector
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  // Widths must match regfile_pkg, since wb_req_t is sized from the package.
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int REG_ID_W = regfile_pkg::REG_ID_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [REG_ID_W-1:0] a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [REG_ID_W-1:0] b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                wr_en,
  output logic [REG_ID_W-1:0] wr_reg,
  output logic [DATA_W-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [REG_ID_W-1:0] rsv_reg,
  input  logic [REG_ID_W-1:0] src1_reg,
  input  logic [REG_ID_W-1:0] src2_reg,
  output logic                src1_busy,
  output logic                src2_busy,
  output logic [NUM_REGS-1:0] busy
);

  wb_req_t w_req_a;
  wb_req_t w_req_b;
  wb_req_t w_win;
  logic    w_grant_a;
  logic    w_grant_b;

  logic                r_wr_en;
  logic [REG_ID_W-1:0] r_wr_reg;
  logic [DATA_W-1:0]   r_wr_data;
  logic [NUM_REGS-1:0] r_busy;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  wb_rr_picker u_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (w_grant_a),
    .b_grant (w_grant_b)
  );

  always_comb begin
    w_req_a.valid  = a_valid;
    w_req_a.reg_id = a_reg;
    w_req_a.data   = a_data;
    w_req_b.valid  = b_valid;
    w_req_b.reg_id = b_reg;
    w_req_b.data   = b_data;
  end

  // At most one side can transfer per cycle: when both are valid exactly one
  // grant is high. w_win.valid therefore doubles as "a transfer happens".
  always_comb begin
    w_win = '0;
    if (w_req_a.valid && w_grant_a) begin
      w_win = w_req_a;
    end else if (w_req_b.valid && w_grant_b) begin
      w_win = w_req_b;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write toward the register file; reg/data hold when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_win.valid;
      if (w_win.valid) begin
        r_wr_reg  <= w_win.reg_id;
        r_wr_data <= w_win.data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write scoreboard. A reservation in the same cycle as a writeback
  // to that register wins, since it represents a newer producer.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    logic w_set;
    logic w_clr;

    assign w_set = rsv_en && (rsv_reg == REG_ID_W'(gi));
    assign w_clr = w_win.valid && (w_win.reg_id == REG_ID_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy[gi] <= 1'b0;
      end else begin
        r_busy[gi] <= w_set | (r_busy[gi] & ~w_clr);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign wr_en     = r_wr_en;
  assign wr_reg    = r_wr_reg;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign src1_busy = r_busy[src1_reg];
  assign src2_busy = r_busy[src2_reg];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Directed steps
//               walk the key scenarios, followed by randomized traffic, all
//               compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_reg;
  logic [3:0]  src1_reg;
  logic [3:0]  src2_reg;
  logic        src1_busy;
  logic        src2_busy;
  logic [15:0] busy;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_reg   (rsv_reg),
    .src1_reg  (src1_reg),
    .src2_reg  (src2_reg),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: who wins the next conflict, pending registers,
  // and the write the register file should currently be seeing.
  int          m_turn;      // 0 = A next on conflict, 1 = B
  logic [15:0] m_busy;
  logic        m_wr_en;
  logic [3:0]  m_wr_reg;
  logic [15:0] m_wr_data;
  logic        last_acc_a;
  logic        last_acc_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_turn    = 0;
    m_busy    = '0;
    m_wr_en   = 1'b0;
    m_wr_reg  = '0;
    m_wr_data = '0;
  endtask

  // One clock cycle with the currently driven inputs: check the combinational
  // outputs before the edge, advance the model, then check registered outputs.
  task automatic tick();
    logic exp_ar, exp_br, acc_a, acc_b;
    #1;
    exp_ar = !(b_valid && m_turn == 1);
    exp_br = !(a_valid && m_turn == 0);
    check("a_ready", a_ready, exp_ar);
    check("b_ready", b_ready, exp_br);
    check("src1_busy", src1_busy, m_busy[src1_reg]);
    check("src2_busy", src2_busy, m_busy[src2_reg]);
    acc_a = a_valid && exp_ar;
    acc_b = b_valid && exp_br;
    @(posedge clk);
    if (acc_a) begin
      m_wr_en = 1'b1; m_wr_reg = a_reg; m_wr_data = a_data; m_busy[a_reg] = 1'b0;
    end else if (acc_b) begin
      m_wr_en = 1'b1; m_wr_reg = b_reg; m_wr_data = b_data; m_busy[b_reg] = 1'b0;
    end else begin
      m_wr_en = 1'b0;
    end
    if (rsv_en) m_busy[rsv_reg] = 1'b1;
    if (a_valid && b_valid) m_turn = 1 - m_turn;
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_reg", wr_reg, m_wr_reg);
    check("wr_data", wr_data, m_wr_data);
    check("busy", busy, m_busy);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    rsv_en = 0; rsv_reg = 0; src1_reg = 0; src2_reg = 0;
    last_acc_a = 0; last_acc_b = 0;
    model_reset();

    // ---- Reset state ----
    #2;
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_ready", b_ready, 1'b1);
    check("rst_wr", {wr_en, wr_reg, wr_data}, 21'd0);
    check("rst_busy", busy, 16'h0000);
    @(posedge clk); #1;
    check("rst_hold_wr_en", wr_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- A only ----
    a_valid = 1; a_reg = 4'd3; a_data = 16'h1234;
    tick();
    check("tp1_wr", {wr_en, wr_reg, wr_data}, {1'b1, 4'd3, 16'h1234});
    a_valid = 0;
    tick();
    check("tp1_idle_hold", {wr_en, wr_reg, wr_data}, {1'b0, 4'd3, 16'h1234});

    // ---- Both held: alternation A,B,A,B ----
    a_valid = 1; a_reg = 4'd5; a_data = 16'hAAAA;
    b_valid = 1; b_reg = 4'd6; b_data = 16'hBBBB;
    tick(); check("tp2_c1", wr_reg, 4'd5);
    tick(); check("tp2_c2", wr_reg, 4'd6);
    tick(); check("tp2_c3", wr_reg, 4'd5);
    tick(); check("tp2_c4", wr_reg, 4'd6);
    a_valid = 0; b_valid = 0;

    // ---- Reserve 7, then B writes 7 ----
    rsv_en = 1; rsv_reg = 4'd7; src1_reg = 4'd7;
    tick();
    check("tp3_src1_set", src1_busy, 1'b1);
    rsv_en = 0;
    b_valid = 1; b_reg = 4'd7; b_data = 16'h7777;
    tick();
    check("tp3_busy7_clr", busy[7], 1'b0);
    check("tp3_src1_clr", src1_busy, 1'b0);
    b_valid = 0;

    // ---- Reserve 9 coincident with A writing 9 ----
    rsv_en = 1; rsv_reg = 4'd9;
    tick();
    a_valid = 1; a_reg = 4'd9; a_data = 16'h9999;
    tick();
    check("tp4_busy9", busy[9], 1'b1);
    check("tp4_wr", {wr_en, wr_reg}, {1'b1, 4'd9});
    rsv_en = 0; a_valid = 0;

    // ---- Same register from both, pointer at B ----
    a_valid = 1; a_reg = 4'd10; a_data = 16'h000A;
    b_valid = 1; b_reg = 4'd11; b_data = 16'h000B;
    tick();
    a_valid = 0;
    tick();
    a_valid = 1; a_reg = 4'd2; a_data = 16'h0001;
    b_valid = 1; b_reg = 4'd2; b_data = 16'h0002;
    tick();
    check("tp5_first", wr_data, 16'h0002);
    b_valid = 0;
    tick();
    check("tp5_second", wr_data, 16'h0001);
    a_valid = 0;

    // ---- Mid-cycle reset with busy=00F0 and a pending write ----
    b_valid = 1; b_reg = 4'd9; b_data = 16'h0909;
    rsv_en = 1; rsv_reg = 4'd4;
    tick();
    b_valid = 0;
    for (int r = 5; r <= 7; r++) begin
      rsv_reg = 4'(r);
      tick();
    end
    rsv_en = 0;
    a_valid = 1; a_reg = 4'd1; a_data = 16'h0101;
    b_valid = 1; b_reg = 4'd0; b_data = 16'h0000;
    tick();
    check("tp6_pre_busy", busy, 16'h00F0);
    check("tp6_pre_wr_en", wr_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("tp6_async_busy", busy, 16'h0000);
    check("tp6_async_wr_en", wr_en, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1; a_reg = 4'd12; a_data = 16'hC0C0;
    b_valid = 1; b_reg = 4'd13; b_data = 16'hD0D0;
    tick();
    check("tp6_ptr_a", {wr_reg, wr_data}, {4'd12, 16'hC0C0});
    a_valid = 0;
    tick();

    // ---- Randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || last_acc_a) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_reg   = 4'($urandom_range(0, 15));
        a_data  = 16'($urandom);
      end
      if (!b_valid || last_acc_b) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_reg   = 4'($urandom_range(0, 15));
        b_data  = 16'($urandom);
      end
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_reg  = 4'($urandom_range(0, 15));
      src1_reg = 4'($urandom_range(0, 15));
      src2_reg = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU) and B (memory load).
- Arbitrates round-robin on conflict and registers the winning write toward the register file.
- Keeps a 16-entry pending-write scoreboard so decode can stall on a source register whose producer has not yet written back.
- Sits between execute/memory writeback and the 16x16 register file.

Parameters:
- NUM_REGS, 16, number of architectural registers; must equal 2**REG_ID_W.
- REG_ID_W, 4, register id width.
- DATA_W, 16, write data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a write.
- a_ready  output  1  requester A is granted this cycle.
- a_reg  input  REG_ID_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- b_valid  input  1  requester B has a write.
- b_ready  output  1  requester B is granted this cycle.
- b_reg  input  REG_ID_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- wr_en  output  1  register-file write enable (registered).
- wr_reg  output  REG_ID_W  register-file destination (registered).
- wr_data  output  DATA_W  register-file write data (registered).
- rsv_en  input  1  decode reserves a destination register.
- rsv_reg  input  REG_ID_W  register being reserved.
- src1_reg  input  REG_ID_W  decode source 1.
- src2_reg  input  REG_ID_W  decode source 2.
- src1_busy  output  1  src1_reg has a pending write.
- src2_busy  output  1  src2_reg has a pending write.
- busy  output  NUM_REGS  scoreboard vector; bit r set while register r is pending.

Behaviour:
- Reset (async assert, sync release): wr_en=0, wr_reg=0, wr_data=0, busy=0, priority pointer=A. a_ready and b_ready follow the combinational rule below, so both are 1 while in reset.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, reg and data stable until accepted; payload changes while valid && !ready are illegal.
  - a_ready = !(b_valid && prio==B); b_ready = !(a_valid && prio==A).
  - ready never depends on the requester's own valid.
- Arbitration:
  - Only one valid: granted the same cycle, no pointer change.
  - Both valid: the pointer side is granted and the pointer flips to the other side at that edge.
  - The register file accepts a write every cycle, so there is no backpressure from the output.
- Output latency is 1 cycle: an acceptance at edge N drives wr_en=1 with that reg/data during cycle N+1. With no acceptance, wr_en=0 and wr_reg/wr_data hold their last values.
- Scoreboard:
  - busy[rsv_reg] sets at the edge where rsv_en=1.
  - busy[r] clears at the edge where a write to r is accepted (same edge as the wr_en capture).
  - Set and clear of the same register in the same cycle: set wins, because a newer producer exists.
  - Reserving an already-busy register leaves it busy (single-bit tracking; the first writeback clears it).
  - srcN_busy = busy[srcN_reg], combinational from the registered vector. There is no same-cycle bypass of rsv_en.
- Accepted writes to a non-busy register are legal: the write is still performed and busy is unchanged.
- A and B targeting the same register in the same cycle: only one is accepted that cycle; the other waits. Order follows the pointer.
- Reset mid-operation: the pending output write is dropped (wr_en=0) and all busy bits clear immediately.

Decomposition:
- Package regfile_pkg:
  - REG_ID_W, DATA_W, NUM_REGS constants.
  - Requester enum {REQ_A, REQ_B}, used for the pointer.
  - wb_req_t struct {valid, reg, data}.
- Sub-module wb_rr_picker: 2-way round-robin grant plus pointer flop, with inputs a_valid/b_valid and outputs a_grant/b_grant.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset then A only (a_reg=3, a_data=16'h1234), held 1 cycle -> a_ready=1; next cycle wr_en=1, wr_reg=3, wr_data=16'h1234; pointer still A.
- A (reg 5, 16'hAAAA) and B (reg 6, 16'hBBBB) valid together, both held -> cycle 1 grants A, then wr_en for reg 5; cycle 2 grants B, then wr_en for reg 6; pointer ends at A. Repeat the pattern and check alternation A,B,A,B.
- rsv_en with rsv_reg=7, then src1_reg=7 -> src1_busy=1 the following cycle; B writes reg 7 -> busy[7]=0 after the acceptance edge, and src1_busy=0.
- rsv_en reg 9 in the same cycle that A's write to reg 9 is accepted -> busy[9] stays 1; wr_en for reg 9 still occurs.
- Both requesters target reg 2 (data 16'h0001 from A, 16'h0002 from B), pointer=B -> write order is 16'h0002 then 16'h0001.
- Assert rst_n=0 mid-cycle while busy=16'h00F0 and an acceptance is pending -> busy=0 and wr_en=0 immediately without waiting for clk; pointer=A after release.
